// File: rtl/mem_pkg.sv
// Shared load/store definitions: op and size encodings, address map and the
// side-band record that follows a load through the BRAM read latency.
package mem_pkg;

    typedef enum logic [1:0] {
        MEM_DISABLE   = 2'b00,
        MEM_READ_SEXT = 2'b01,
        MEM_READ_ZEXT = 2'b10,
        MEM_WRITE     = 2'b11
    } mem_op_e;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALFWORD  = 2'b01,
        WORD      = 2'b10,
        SIZE_RSVD = 2'b11
    } mem_size_e;

    localparam logic [31:0] DATA_BRAM_BASE = 32'h0000_0000;
    localparam logic [31:0] MMIO_BASE      = 32'h0000_A000;
    localparam logic [31:0] MMIO_IN_ADDR   = 32'h0000_A004;

    typedef struct packed {
        logic      valid;
        mem_op_e   op;
        mem_size_e size;
        logic [1:0] offset;
        logic [4:0] rd;
        logic      is_mmio;
    } load_sb_t;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        misaligned;
    } load_result_t;

    function automatic logic is_load(input logic [1:0] op);
        return (op == MEM_READ_SEXT) || (op == MEM_READ_ZEXT);
    endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational lane extraction and sign/zero extension of a lane-ordered
// BRAM word; byte offset k lives in word[31-8k -: 8].
module load_extract (
    input  logic [31:0] word,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [1:0]  op,
    output logic [31:0] data,
    output logic        misaligned
);
    import mem_pkg::*;

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic        sext;

    assign sext = (op == MEM_READ_SEXT);

    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        data       = '0;
        misaligned = 1'b0;
        byte_val   = '0;
        half_val   = '0;
        case (offset)
            2'd0:    byte_val = word[31:24];
            2'd1:    byte_val = word[23:16];
            2'd2:    byte_val = word[15:8];
            default: byte_val = word[7:0];
        endcase
        half_val = offset[1] ? {word[7:0], word[15:8]} : {word[23:16], word[31:24]};

        case (mem_size_e'(size))
            BYTE: begin
                data = sext ? {{24{byte_val[7]}}, byte_val} : {24'b0, byte_val};
            end
            HALFWORD: begin
                if (offset[0]) misaligned = 1'b1;
                else data = sext ? {{16{half_val[15]}}, half_val} : {16'b0, half_val};
            end
            WORD: begin
                if (offset != 2'd0) misaligned = 1'b1;
                else data = {word[7:0], word[15:8], word[23:16], word[31:24]};
            end
            default: misaligned = 1'b1;
        endcase

        if (misaligned) data = '0;
    end

endmodule

// File: rtl/mem_load_return.sv
// Load return path: side-band pipeline matched to BRAM latency, lane
// extraction, and a credit-controlled result FIFO. Optional MMIO_READ_EN.
module mem_load_return #(
    parameter int          READ_LATENCY = 1,
    parameter int          FIFO_DEPTH   = 2,
    parameter logic [31:0] MMIO_IN_ADDR = mem_pkg::MMIO_IN_ADDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [4:0]  req_rd,
    input  logic [31:0] bram_dout,
    input  logic [31:0] mmio_in,
    output logic        ld_valid,
    input  logic        ld_ready,
    output logic [31:0] ld_data,
    output logic [4:0]  ld_rd,
    output logic        ld_misaligned
);
    import mem_pkg::*;

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

    logic         accept;
    logic         push;
    logic         pop;
    load_sb_t     sb_in;
    load_sb_t     sb_out;
    load_sb_t     pipe_q [READ_LATENCY];
    logic [31:0]  src_word;
    load_result_t result;

    load_result_t     fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
    logic [CNT_W-1:0] credits_q, credits_d;

    // Credits cover both in-flight loads and buffered results, so a full count
    // guarantees every returning load still finds a FIFO entry.
    assign req_ready = (credits_q < DEPTH_C);
    assign accept    = req_valid && req_ready && is_load(req_op);

    always_comb begin
        sb_in         = '0;
        sb_in.valid   = accept;
        sb_in.op      = mem_op_e'(req_op);
        sb_in.size    = mem_size_e'(req_size);
        sb_in.offset  = req_addr[1:0];
        sb_in.rd      = req_rd;
        sb_in.is_mmio = (req_addr[31:2] == MMIO_IN_ADDR[31:2]);
    end

    // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= sb_in;
            for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign sb_out = pipe_q[READ_LATENCY-1];

`ifdef MMIO_READ_EN
    logic [31:0] mmio_meta_q;
    logic [31:0] mmio_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mmio_meta_q <= '0;
            mmio_sync_q <= '0;
        end else begin
            mmio_meta_q <= mmio_in;
            mmio_sync_q <= mmio_meta_q;
        end
    end

    assign src_word = sb_out.is_mmio ? mmio_sync_q : bram_dout;
`else
    logic unused_ok;
    assign unused_ok = ^{mmio_in, sb_out.is_mmio};
    assign src_word  = bram_dout;
`endif

    load_extract u_extract (
        .word       (src_word),
        .size       (sb_out.size),
        .offset     (sb_out.offset),
        .op         (sb_out.op),
        .data       (result.data),
        .misaligned (result.misaligned)
    );
    assign result.rd = sb_out.rd;

    assign push     = sb_out.valid;
    assign ld_valid = (fifo_cnt_q != '0);
    assign pop      = ld_valid && ld_ready;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        fifo_cnt_d = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
        credits_d  = credits_q + CNT_W'(accept) - CNT_W'(pop);
    end

    // NOTE: the result buffer is a handful of flops, so it is reset to keep the head outputs at zero after reset; a large RAM would not be.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            credits_q  <= '0;
        end else begin
            if (push) fifo_q[wr_ptr_q] <= result;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            credits_q  <= credits_d;
        end
    end

    assign ld_data       = fifo_q[rd_ptr_q].data;
    assign ld_rd         = fifo_q[rd_ptr_q].rd;
    assign ld_misaligned = fifo_q[rd_ptr_q].misaligned;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !pop && fifo_cnt_q == DEPTH_C));
        end
    end

endmodule

// File: tb/tb_mem_load_return.sv
// Directed bench for mem_load_return with default parameters
// (READ_LATENCY=1, FIFO_DEPTH=2); optional MMIO_READ_EN expectations.
module tb_mem_load_return;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [4:0]  req_rd;
    logic [31:0] bram_dout;
    logic [31:0] mmio_in;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd;
    logic        ld_misaligned;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mem_load_return dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_size      (req_size),
        .req_addr      (req_addr),
        .req_rd        (req_rd),
        .bram_dout     (bram_dout),
        .mmio_in       (mmio_in),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_data       (ld_data),
        .ld_rd         (ld_rd),
        .ld_misaligned (ld_misaligned)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // One load with ld_ready=1: accept in cycle T, BRAM data in T+1, result in T+2.
    task automatic do_load(input string tag, input logic [1:0] op, input logic [1:0] size,
                           input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] dout,
                           input logic [31:0] exp_data, input logic exp_mis);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_op = op; req_size = size; req_addr = addr; req_rd = rd;
        tick();
        req_valid = 1'b0;
        bram_dout = dout;
        check({tag, "_early_valid"}, 32'(ld_valid), 32'd0);
        tick();
        bram_dout = 32'hDEAD_BEEF;
        check({tag, "_valid"}, 32'(ld_valid), 32'd1);
        check({tag, "_data"}, ld_data, exp_data);
        check({tag, "_rd"}, 32'(ld_rd), 32'(rd));
        check({tag, "_mis"}, 32'(ld_misaligned), 32'(exp_mis));
        tick();
        check({tag, "_popped"}, 32'(ld_valid), 32'd0);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_size = 2'b00;
        req_addr = '0; req_rd = '0; bram_dout = '0; mmio_in = '0; ld_ready = 1'b0;
        tick();
        check("rst_ld_valid", 32'(ld_valid), 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        check("rst_ld_rd", 32'(ld_rd), 32'd0);
        check("rst_ld_mis", 32'(ld_misaligned), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        tick();
        reset = 1'b0;
        ld_ready = 1'b1;
        tick();

        do_load("lw",       2'b01, 2'b10, 32'h100, 5'd5,  32'h7856_3412, 32'h1234_5678, 1'b0);
        do_load("lb_sext",  2'b01, 2'b00, 32'h103, 5'd6,  32'h0000_00F0, 32'hFFFF_FFF0, 1'b0);
        do_load("lbu",      2'b10, 2'b00, 32'h103, 5'd7,  32'h0000_00F0, 32'h0000_00F0, 1'b0);
        do_load("lb_off0",  2'b01, 2'b00, 32'h100, 5'd8,  32'h8011_2233, 32'hFFFF_FF80, 1'b0);
        do_load("lh_sext",  2'b01, 2'b01, 32'h102, 5'd9,  32'h0000_0080, 32'hFFFF_8000, 1'b0);
        do_load("lhu_off0", 2'b10, 2'b01, 32'h100, 5'd10, 32'hAABB_CCDD, 32'h0000_BBAA, 1'b0);
        do_load("lh_mis",   2'b01, 2'b01, 32'h101, 5'd11, 32'h1234_5678, 32'h0000_0000, 1'b1);
        do_load("lw_mis",   2'b10, 2'b10, 32'h102, 5'd12, 32'h1234_5678, 32'h0000_0000, 1'b1);
        do_load("size11",   2'b01, 2'b11, 32'h100, 5'd13, 32'h1234_5678, 32'h0000_0000, 1'b1);

        // Write and disable ops must neither allocate a slot nor consume a credit.
        req_valid = 1'b1; req_op = 2'b11; req_size = 2'b10; req_addr = 32'h200;
        tick();
        tick();
        req_op = 2'b00;
        tick();
        req_valid = 1'b0;
        check("nonload_req_ready", 32'(req_ready), 32'd1);
        check("nonload_no_valid", 32'(ld_valid), 32'd0);
        tick();
        check("nonload_no_valid2", 32'(ld_valid), 32'd0);

        // Back-to-back loads stalled by writeback.
        ld_ready = 1'b0;
        req_valid = 1'b1; req_op = 2'b01; req_size = 2'b10; req_addr = 32'h200; req_rd = 5'd1;
        tick();
        check("bb_ready_after1", 32'(req_ready), 32'd1);
        req_rd = 5'd2; req_addr = 32'h204;
        bram_dout = 32'h1122_3344;
        tick();
        req_valid = 1'b0;
        bram_dout = 32'h5566_7788;
        check("bb_ready_after2", 32'(req_ready), 32'd0);
        check("bb_head_valid", 32'(ld_valid), 32'd1);
        check("bb_head_data", ld_data, 32'h4433_2211);
        req_valid = 1'b1; req_rd = 5'd3; req_addr = 32'h208;
        tick();
        bram_dout = 32'h0;
        check("bb_stall_data", ld_data, 32'h4433_2211);
        check("bb_stall_rd", 32'(ld_rd), 32'd1);
        check("bb_stall_ready", 32'(req_ready), 32'd0);
        tick();
        tick();
        check("bb_stall_data2", ld_data, 32'h4433_2211);
        check("bb_stall_valid2", 32'(ld_valid), 32'd1);
        req_valid = 1'b0;
        ld_ready = 1'b1;
        tick();
        check("bb_second_valid", 32'(ld_valid), 32'd1);
        check("bb_second_data", ld_data, 32'h8877_6655);
        check("bb_second_rd", 32'(ld_rd), 32'd2);
        check("bb_ready_back", 32'(req_ready), 32'd1);
        tick();
        check("bb_drained", 32'(ld_valid), 32'd0);
        tick();
        check("bb_no_third", 32'(ld_valid), 32'd0);

        // Reset with two loads outstanding discards them.
        ld_ready = 1'b0;
        req_valid = 1'b1; req_op = 2'b10; req_size = 2'b00; req_addr = 32'h300; req_rd = 5'd20;
        tick();
        req_rd = 5'd21;
        bram_dout = 32'hFFFF_FFFF;
        tick();
        req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ld_ready = 1'b1;
        check("rst_mid_ready", 32'(req_ready), 32'd1);
        check("rst_mid_valid", 32'(ld_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst_mid_quiet%0d", i), 32'(ld_valid), 32'd0);
        end

        // MMIO input register load.
        mmio_in = 32'hCAFE_BABE;
        tick(); tick(); tick();
`ifdef MMIO_READ_EN
        do_load("mmio_lw", 2'b01, 2'b10, 32'hA004, 5'd30, 32'h0102_0304, 32'hBEBA_FECA, 1'b0);
        do_load("mmio_lh", 2'b01, 2'b01, 32'hA006, 5'd31, 32'h0102_0304, 32'hFFFF_BEBA, 1'b0);
`else
        do_load("mmio_lw", 2'b01, 2'b10, 32'hA004, 5'd30, 32'h0102_0304, 32'h0403_0201, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
